// File: rtl/vip_column_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vip_column_scheduler
// Brief    : Column-at-a-time sequencer for a bank of M VIP units (fetch B
//            column, start, collect done flags, drain results to C).
//            Optional VIP watchdog is enabled by defining VIP_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module vip_column_scheduler #(
    parameter int M          = 4,
    parameter int P          = 4,
    parameter int N          = 4,
    parameter int WORD_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     a_stb,
    input  logic                                     b_stb,
    output logic                                     a_ack,
    output logic                                     b_ack,
    output logic                                     b_rd_en,
    output logic [((P*N > 1) ? $clog2(P*N) : 1)-1:0] b_rd_addr,
    input  logic [WORD_WIDTH-1:0]                    b_rd_data,
    output logic [P*WORD_WIDTH-1:0]                  vip_column,
    output logic                                     vip_start,
    input  logic [M-1:0]                             vip_done,
    input  logic [M*WORD_WIDTH-1:0]                  vip_result,
    output logic                                     c_wr_en,
    output logic [((M*N > 1) ? $clog2(M*N) : 1)-1:0] c_wr_addr,
    output logic [WORD_WIDTH-1:0]                    c_wr_data,
    output logic                                     c_stb,
    input  logic                                     c_ack,
    output logic                                     busy,
    output logic                                     err
);

    localparam int c_baw = (P*N > 1) ? $clog2(P*N) : 1;
    localparam int c_caw = (M*N > 1) ? $clog2(M*N) : 1;
    localparam int c_fw  = $clog2(P+1);
    localparam int c_kw  = (P > 1) ? $clog2(P) : 1;
    localparam int c_ww  = (M > 1) ? $clog2(M) : 1;
    localparam int c_nw  = (N > 1) ? $clog2(N) : 1;

    localparam logic [c_fw-1:0] c_fetch_last = c_fw'(P);
    localparam logic [c_fw-1:0] c_fetch_one  = c_fw'(1);
    localparam logic [c_ww-1:0] c_wr_last    = c_ww'(M-1);
    localparam logic [c_nw-1:0] c_cw_last    = c_nw'(N-1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [c_nw-1:0]       r_cw;
    logic [c_fw-1:0]       r_fetch_cnt;
    logic [c_kw-1:0]       w_fetch_slot;
    logic [c_ww-1:0]       r_wr_idx;
    logic [M-1:0]          r_mask;
    logic [M-1:0]          w_mask_next;
    logic [WORD_WIDTH-1:0] r_column [P];
    logic [WORD_WIDTH-1:0] r_result [M];

`ifdef VIP_TIMEOUT_EN
    localparam int              c_tw       = $clog2(TIMEOUT+1);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT-1);
    logic [c_tw-1:0]            r_wait_cnt;
    logic                       r_err;
    logic                       w_timeout;
`endif

    // Read data lags the strobe by one cycle, so count k lands in slot k-1.
    assign w_fetch_slot = c_kw'(r_fetch_cnt - c_fetch_one);
    assign busy         = (r_state != S_IDLE);

    for (genvar k = 0; k < P; k++) begin : g_col
        assign vip_column[k*WORD_WIDTH +: WORD_WIDTH] = r_column[k];
    end

    always_comb begin
        w_next_state = r_state;
        w_mask_next  = r_mask;
        b_rd_en      = 1'b0;
        b_rd_addr    = '0;
        vip_start    = 1'b0;
        c_wr_en      = 1'b0;
        c_wr_addr    = '0;
        c_wr_data    = '0;
        c_stb        = 1'b0;
        a_ack        = 1'b0;
        b_ack        = 1'b0;
`ifdef VIP_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (a_stb && b_stb) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_fetch_cnt != c_fetch_last) begin
                    b_rd_en   = 1'b1;
                    b_rd_addr = c_baw'(int'(r_fetch_cnt) * N + int'(r_cw));
                end else begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                vip_start    = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_mask_next = r_mask | vip_done;
                if (&w_mask_next) begin
                    w_next_state = S_WRITE;
                end
`ifdef VIP_TIMEOUT_EN
                else if (r_wait_cnt == c_tmo_last) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_DONE;
                end
`endif
            end
            S_WRITE: begin
                c_wr_en   = 1'b1;
                c_wr_addr = c_caw'(int'(r_wr_idx) * N + int'(r_cw));
                c_wr_data = r_result[r_wr_idx];
                if (r_wr_idx == c_wr_last) begin
                    w_next_state = (r_cw == c_cw_last) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                c_stb = 1'b1;
                a_ack = 1'b1;
                b_ack = 1'b1;
                if (c_ack) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cw        <= '0;
            r_fetch_cnt <= '0;
            r_wr_idx    <= '0;
            r_mask      <= '0;
            for (int k = 0; k < P; k++) begin
                r_column[k] <= '0;
            end
            for (int i = 0; i < M; i++) begin
                r_result[i] <= '0;
            end
        end else begin
            r_state     <= w_next_state;
            r_fetch_cnt <= '0;
            case (r_state)
                S_IDLE: r_cw <= '0;
                S_FETCH: begin
                    if (r_fetch_cnt != c_fetch_last) begin
                        r_fetch_cnt <= r_fetch_cnt + c_fetch_one;
                    end
                    if (r_fetch_cnt != '0) begin
                        r_column[w_fetch_slot] <= b_rd_data;
                    end
                end
                S_START: r_mask <= '0;
                S_WAIT: begin
                    r_mask <= w_mask_next;
                    if (&w_mask_next) begin
                        for (int i = 0; i < M; i++) begin
                            r_result[i] <= vip_result[i*WORD_WIDTH +: WORD_WIDTH];
                        end
                    end
                end
                S_WRITE: begin
                    if (r_wr_idx == c_wr_last) begin
                        r_wr_idx <= '0;
                        if (r_cw != c_cw_last) begin
                            r_cw <= r_cw + c_nw'(1);
                        end
                    end else begin
                        r_wr_idx <= r_wr_idx + c_ww'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VIP_TIMEOUT_EN
    // Watchdog restarts on every WAIT entry; err lives until the job is acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + c_tw'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (r_state == S_DONE && c_ack) begin
                r_err <= 1'b0;
            end
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vip_column_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vip_column_scheduler
// Brief    : Scoreboard bench for vip_column_scheduler (M=2, P=4, N=4).
// Revision : 1.0
// ============================================================================
module tb_vip_column_scheduler;

    localparam int M   = 2;
    localparam int P   = 4;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int TMO = 16;

    logic            clk;
    logic            rst;
    logic            a_stb, b_stb, a_ack, b_ack;
    logic            b_rd_en;
    logic [3:0]      b_rd_addr;
    logic [W-1:0]    b_rd_data;
    logic [P*W-1:0]  vip_column;
    logic            vip_start;
    logic [M-1:0]    vip_done;
    logic [M*W-1:0]  vip_result;
    logic            c_wr_en;
    logic [2:0]      c_wr_addr;
    logic [W-1:0]    c_wr_data;
    logic            c_stb, c_ack, busy, err;

    vip_column_scheduler #(
        .M(M), .P(P), .N(N), .WORD_WIDTH(W), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .a_stb(a_stb), .b_stb(b_stb), .a_ack(a_ack), .b_ack(b_ack),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .vip_column(vip_column), .vip_start(vip_start),
        .vip_done(vip_done), .vip_result(vip_result),
        .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
        .c_stb(c_stb), .c_ack(c_ack), .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // B memory holds addr+1; A = [[1,2,3,4],[5,6,7,8]].
    // Column c of B = [c+1, c+5, c+9, c+13] -> C[0][c] = 10c+90, C[1][c] = 26c+202.
    int rd_tab[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int wa_tab[8]  = '{0, 4, 1, 5, 2, 6, 3, 7};
    int wd_tab[8]  = '{90, 202, 100, 228, 110, 254, 120, 280};
    int a_mat[2][4] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}};

    int rd_q[$];
    int wa_q[$];
    int wd_q[$];

    int lat0, lat1, dmax;
    bit level, en1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_job(input int ncols, input bit with_writes);
        for (int j = 0; j < ncols*P; j++) rd_q.push_back(rd_tab[j]);
        if (with_writes) begin
            for (int j = 0; j < 8; j++) begin
                wa_q.push_back(wa_tab[j]);
                wd_q.push_back(wd_tab[j]);
            end
        end
    endtask

    task automatic check_zero();
        chk("rst_ctrl", {a_ack, b_ack, c_stb, b_rd_en, vip_start, c_wr_en, busy, err}, 0);
        chk("rst_addr", {b_rd_addr, c_wr_addr}, 0);
        chk("rst_col", vip_column, 0);
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (!a_ack && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ack_seen", a_ack, 1);
    endtask

    task automatic finish_job();
        a_stb = 1'b0;
        b_stb = 1'b0;
        c_ack = 1'b1;
        @(negedge clk);
        c_ack = 1'b0;
        chk("ack_drop", {c_stb, a_ack, b_ack, busy}, 0);
        chk("wr_q_empty", wa_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
    endtask

    // B memory: data returned one cycle after the strobe, junk otherwise.
    initial begin : b_mem
        bit          pend_v;
        logic [31:0] pend_d;
        pend_v    = 1'b0;
        pend_d    = '0;
        b_rd_data = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            b_rd_data = pend_v ? pend_d : 32'hDEAD_BEEF;
            pend_v    = b_rd_en;
            pend_d    = 32'(b_rd_addr) + 32'd1;
        end
    end

    // VIP bank: per-unit latency, pulse or level done, results valid from dmax.
    initial begin : vip_model
        int          age;
        bit          running;
        logic [31:0] acc;
        vip_done   = '0;
        vip_result = {2{32'hBAD0_BAD0}};
        running    = 1'b0;
        age        = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                running  = 1'b0;
                vip_done = '0;
            end else if (vip_start) begin
                running    = 1'b1;
                age        = 0;
                vip_done   = '0;
                vip_result = {2{32'hBAD0_BAD0}};
            end else if (running) begin
                age++;
                if (age == lat0) vip_done[0] = 1'b1;
                else if (!level && age == lat0 + 1) vip_done[0] = 1'b0;
                if (en1 && age == lat1) vip_done[1] = 1'b1;
                else if (!level && age == lat1 + 1) vip_done[1] = 1'b0;
                if (age == dmax) begin
                    for (int i = 0; i < M; i++) begin
                        acc = '0;
                        for (int k = 0; k < P; k++) begin
                            acc = acc + 32'(a_mat[i][k]) * vip_column[k*W +: W];
                        end
                        vip_result[i*W +: W] = acc;
                    end
                end else if (!level && age == dmax + 1) begin
                    vip_result = {2{32'hBAD0_BAD0}};
                end
            end
        end
    end

    initial begin : monitor
        int t_rd0, t_st;
        bit prev_rd, wr_pend;
        t_rd0 = 0; t_st = 0; prev_rd = 1'b0; wr_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd = 1'b0;
                wr_pend = 1'b0;
            end else begin
                if (b_rd_en) begin
                    if (!prev_rd) t_rd0 = cyc;
                    if (rd_q.size() == 0) chk("rd_extra", b_rd_en, 0);
                    else chk("rd_addr", b_rd_addr, rd_q.pop_front());
                end
                if (vip_start) begin
                    chk("start_lat", cyc - t_rd0, P + 1);
                    t_st    = cyc;
                    wr_pend = 1'b1;
                end
                if (c_wr_en) begin
                    if (wr_pend) begin
                        chk("wr_lat", cyc - t_st, dmax + 1);
                        wr_pend = 1'b0;
                    end
                    if (wa_q.size() == 0) begin
                        chk("wr_extra", c_wr_en, 0);
                    end else begin
                        chk("wr_addr", c_wr_addr, wa_q.pop_front());
                        chk("wr_data", c_wr_data, wd_q.pop_front());
                    end
                end
                prev_rd = b_rd_en;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation hung");
    end

    initial begin : driver
        int n;
        rst = 1'b1; a_stb = 1'b0; b_stb = 1'b0; c_ack = 1'b0;
        lat0 = 3; lat1 = 3; dmax = 3; level = 1'b1; en1 = 1'b1;
        repeat (3) @(negedge clk);
        check_zero();
        rst = 1'b0;
        @(negedge clk);

        // Job 1: uniform latency, level done, long hold in DONE.
        push_job(4, 1'b1);
        a_stb = 1'b1; b_stb = 1'b1;
        wait_ack();
        a_stb = 1'b0; b_stb = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("done_hold", {c_stb, a_ack, b_ack, busy, err}, 5'b11110);
            @(negedge clk);
        end
        finish_job();
        @(negedge clk);

        // Job 2: skewed pulses, stb dropped and stray c_ack mid-job.
        lat0 = 2; lat1 = 7; dmax = 7; level = 1'b0;
        push_job(4, 1'b1);
        a_stb = 1'b1; b_stb = 1'b1;
        repeat (3) @(negedge clk);
        a_stb = 1'b0; b_stb = 1'b0;
        c_ack = 1'b1;
        @(negedge clk);
        c_ack = 1'b0;
        wait_ack();
        finish_job();
        @(negedge clk);

        // Job 3: reset during column-1 write, then a fresh job from cw=0.
        lat0 = 3; lat1 = 3; dmax = 3; level = 1'b1;
        push_job(4, 1'b1);
        a_stb = 1'b1; b_stb = 1'b1;
        n = 0;
        while (!(c_wr_en && c_wr_addr == 3'd1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("col1_write_seen", c_wr_en, 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero();
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        push_job(4, 1'b1);
        rst = 1'b0;
        wait_ack();
        finish_job();
        @(negedge clk);

        // Job 4: unit 1 never finishes.
        en1 = 1'b0; level = 1'b1; lat0 = 3; dmax = 3;
        push_job(1, 1'b0);
        a_stb = 1'b1; b_stb = 1'b1;
        n = 0;
        while (!vip_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_start_seen", vip_start, 1);
        a_stb = 1'b0; b_stb = 1'b0;
`ifdef VIP_TIMEOUT_EN
        n = 0;
        while (!c_stb && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_lat", n, TMO + 1);
        chk("tmo_err", err, 1);
        chk("tmo_acks", {a_ack, b_ack}, 2'b11);
        c_ack = 1'b1;
        @(negedge clk);
        c_ack = 1'b0;
        chk("tmo_clear", {err, busy, c_stb}, 0);
`else
        repeat (1000) @(negedge clk);
        chk("no_tmo_state", {busy, c_stb, err}, 3'b100);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("no_tmo_idle", busy, 0);
`endif
        chk("tmo_rd_q_empty", rd_q.size(), 0);
        chk("tmo_wr_q_empty", wa_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vip_column_scheduler.md
Name: vip_column_scheduler

Overview:
Sequences the bank of M vector-inner-product (VIP) units in the matrix multiplier, one column of B at a time.
- Fetches column cw of B from a word-wide B memory and presents it to all VIP units.
- Pulses start and collects the per-unit done flags.
- Drains the M results serially into a C write port.
- Runs the stb/ack operand and result handshakes with the upstream producer and downstream consumer.

Parameters:
M, 4, rows of A/C = number of VIP units
P, 4, inner dimension (words per VIP column)
N, 4, columns of B/C
WORD_WIDTH, 32, bits per matrix element
TIMEOUT, 1024, VIP watchdog limit in cycles (used only with VIP_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
a_stb  in  1  matrix A valid; held until a_ack
b_stb  in  1  matrix B memory loaded; held until b_ack
a_ack  out  1  A operands released (job complete)
b_ack  out  1  B operands released (job complete)
b_rd_en  out  1  B memory read strobe
b_rd_addr  out  $clog2(P*N)  row-major address k*N+cw
b_rd_data  in  WORD_WIDTH  read data, valid exactly 1 cycle after b_rd_en
vip_column  out  P*WORD_WIDTH  element k at [k*WORD_WIDTH +: WORD_WIDTH], ascending [0:..] vector
vip_start  out  1  one-cycle start pulse to all VIP units
vip_done  in  M  per-unit done; pulse or level
vip_result  in  M*WORD_WIDTH  unit i result at [i*WORD_WIDTH +: WORD_WIDTH]
c_wr_en  out  1  C write strobe
c_wr_addr  out  $clog2(M*N)  row-major address i*N+cw
c_wr_data  out  WORD_WIDTH  C element
c_stb  out  1  matrix C complete
c_ack  in  1  consumer accepted C
busy  out  1  high in every state except IDLE
err  out  1  watchdog fired for current job

Behaviour:
- Reset state: IDLE. All outputs 0: a_ack, b_ack, c_stb, b_rd_en, vip_start, c_wr_en, busy, err, addresses, vip_column. cw=0, done mask=0.
- rst wins over every other input. Reset mid-job aborts the job: no further writes, no acks.
- IDLE: when a_stb & b_stb are both sampled high, set cw=0 and go to FETCH.
- FETCH:
  - Issue P reads, k=0..P-1, on consecutive cycles: b_rd_en=1, b_rd_addr=k*N+cw.
  - Capture b_rd_data one cycle later into vip_column slot k.
  - After the last capture (P+1 cycles after FETCH entry), go to START.
- START:
  - vip_start=1 for exactly one cycle; done mask cleared the same cycle. vip_column holds stable until the next FETCH.
  - Go to WAIT.
- WAIT:
  - Each vip_done bit sets its sticky mask bit. Bits arriving in the START cycle are ignored.
  - In the cycle the mask becomes all-ones (including the cycle the last bit arrives), register vip_result into an internal M-word buffer and go to WRITE.
- WRITE:
  - M cycles, i=0..M-1: c_wr_en=1, c_wr_addr=i*N+cw, c_wr_data=buffer word i.
  - After i=M-1: if cw==N-1 go to DONE; else cw+=1 and go to FETCH.
- DONE:
  - c_stb=a_ack=b_ack=1, held.
  - On c_ack: all three drop the next cycle and the block returns to IDLE. A new job may start the cycle after that.
- Latency per column: (P+1) + 1 + t_vip + M cycles. No overlap between columns.
- Ignored inputs:
  - a_stb/b_stb deasserted mid-job (job continues).
  - c_ack outside DONE.
  - vip_done outside WAIT.
- Degenerate sizes: M=P=N=1 must work. Address widths use $clog2 with a minimum of 1 bit.

Optional Feature:
VIP_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT and resets on WAIT entry.
  - If it reaches TIMEOUT with the mask still incomplete: set err=1, skip the remaining writes and columns, go to DONE. Handshake proceeds normally.
  - err clears on leaving DONE.
- Undefined: no counter; err tied 0; WAIT waits indefinitely.

Test Plan:
- M=P=N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], VIP model with 3-cycle latency -> C writes in order addr0=19, addr2=43, addr1=22, addr3=50; then c_stb=a_ack=b_ack=1 until c_ack, then IDLE.
- B read timing: column 1 with P=4, N=4 -> b_rd_addr sequence 1,5,9,13 on consecutive cycles; vip_start fires exactly 5 cycles after the first read.
- Skewed done: unit0 done at +2, unit1 at +7 (pulses) -> single transition to WRITE at +7; results sampled that cycle.
- c_ack held low 20 cycles in DONE -> c_stb, a_ack, b_ack stay high; c_ack pulse -> all low next cycle; busy=0.
- rst asserted during WRITE of column 1 -> next cycle all outputs 0, state IDLE; with a_stb & b_stb still high, a fresh job restarts at cw=0.
- With VIP_TIMEOUT_EN and TIMEOUT=16, vip_done[1] never asserted -> err=1 and c_stb=1 at 16 cycles after WAIT entry, no c_wr_en for that column; without the macro, still in WAIT after 1000 cycles, err=0.
